// File: rtl/alu_pipe_param.sv
// Two-stage pipelined ALU with valid/ready handshaking on input and output.
// Optional ALU_STICKY_OVERFLOW_EN adds a sticky overflow register cleared only by rst_n.
module alu_pipe_param #(
  parameter  int WIDTH = 128,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [SHW-1:0]   shiftValue,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             carryFlag,
  output logic             zeroFlag,
  output logic             overFlowFlag,
  output logic             illegalOp,
  output logic             stickyOverflow
);

  typedef enum logic [3:0] {
    OP_ROL  = 4'd0,
    OP_ROR  = 4'd1,
    OP_MAX  = 4'd2,
    OP_MIN  = 4'd3,
    OP_NAND = 4'd4,
    OP_SLTU = 4'd5,
    OP_XOR  = 4'd6,
    OP_ADD  = 4'd7,
    OP_SUB  = 4'd8,
    OP_SLT  = 4'd9
  } op_e;

  logic             r_s1_valid;
  logic [3:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [SHW-1:0]   r_s1_sh;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_ovf;
  logic             r_ill;

  logic             w_s1_en;
  logic             w_s2_en;
  logic [SHW-1:0]   w_amt;
  logic [2*WIDTH-1:0] w_dbl_l;
  logic [2*WIDTH-1:0] w_dbl_r;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_ill;

  // A stage may load when it is empty or its contents move on this cycle.
  assign w_s2_en = !r_s2_valid || outReady;
  assign w_s1_en = !r_s1_valid || w_s2_en;
  assign inReady = w_s1_en;

  // Rotating a doubled operand keeps every shift amount strictly below 2*WIDTH.
  assign w_amt   = SHW'(32'(r_s1_sh) % 32'(WIDTH));
  assign w_dbl_l = {r_s1_a, r_s1_a} << w_amt;
  assign w_dbl_r = {r_s1_a, r_s1_a} >> w_amt;
  assign w_rol   = w_dbl_l[2*WIDTH-1:WIDTH];
  assign w_ror   = w_dbl_r[WIDTH-1:0];
  assign w_sum   = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_diff  = {1'b0, r_s1_a} - {1'b0, r_s1_b};

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_ill   = 1'b0;
    case (r_s1_op)
      OP_ROL: begin
        w_res   = w_rol;
        w_carry = (w_amt != '0) && w_rol[0];
      end
      OP_ROR: begin
        w_res   = w_ror;
        w_carry = (w_amt != '0) && w_ror[WIDTH-1];
      end
      OP_MAX:  w_res = (r_s1_a > r_s1_b) ? r_s1_a : r_s1_b;
      OP_MIN:  w_res = (r_s1_a <= r_s1_b) ? r_s1_a : r_s1_b;
      OP_NAND: w_res = ~(r_s1_a & r_s1_b);
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, r_s1_a < r_s1_b};
      OP_XOR:  w_res = r_s1_a ^ r_s1_b;
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = !w_diff[WIDTH];
        w_ovf   = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                  (w_diff[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(r_s1_a) < $signed(r_s1_b)};
      default: w_ill = 1'b1;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together
  // at the edge; datapath registers are reset too, so outputs read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_sh    <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= inValid;
      if (inValid) begin
        r_s1_op <= opcode;
        r_s1_a  <= input1;
        r_s1_b  <= input2;
        r_s1_sh <= shiftValue;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
      r_ill      <= 1'b0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_res;
        r_carry  <= w_carry;
        r_zero   <= ~|w_res;
        r_ovf    <= w_ovf;
        r_ill    <= w_ill;
      end
    end
  end

  assign outValid     = r_s2_valid;
  assign result       = r_result;
  assign carryFlag    = r_carry;
  assign zeroFlag     = r_zero;
  assign overFlowFlag = r_ovf;
  assign illegalOp    = r_ill;

`ifdef ALU_STICKY_OVERFLOW_EN
  logic r_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sticky <= 1'b0;
    else if (r_s2_valid && outReady && r_ovf)
      r_sticky <= 1'b1;
  end

  assign stickyOverflow = r_sticky;
`else
  assign stickyOverflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe_param.sv
// Scoreboard bench for alu_pipe_param: directed beats push expected results,
// a negedge monitor pops and compares each consumed output beat.
module tb_alu_pipe_param;

  localparam int WIDTH = 128;
  localparam int SHW   = $clog2(WIDTH);

  logic             clk;
  logic             rst_n;
  logic             inValid;
  logic             inReady;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [SHW-1:0]   shiftValue;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] result;
  logic             carryFlag;
  logic             zeroFlag;
  logic             overFlowFlag;
  logic             illegalOp;
  logic             stickyOverflow;

  alu_pipe_param #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inValid       (inValid),
    .inReady       (inReady),
    .opcode        (opcode),
    .input1        (input1),
    .input2        (input2),
    .shiftValue    (shiftValue),
    .outValid      (outValid),
    .outReady      (outReady),
    .result        (result),
    .carryFlag     (carryFlag),
    .zeroFlag      (zeroFlag),
    .overFlowFlag  (overFlowFlag),
    .illegalOp     (illegalOp),
    .stickyOverflow(stickyOverflow)
  );

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             z;
    logic             v;
    logic             ill;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: toggle each cycle, 2: never ready
  int   n_stalls = 0;

  localparam logic [WIDTH-1:0] ONES   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ENDS   = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [WIDTH-1:0] res, input logic c,
                              input logic z, input logic v, input logic ill);
    exp_t e;
    e.res = res; e.c = c; e.z = z; e.v = v; e.ill = ill;
    return e;
  endfunction

  // Inputs change 1ns after the rising edge; acceptance is judged at the negedge.
  task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [SHW-1:0] sh,
                      input exp_t e);
    bit accepted = 0;
    opcode = op; input1 = a; input2 = b; shiftValue = sh; inValid = 1'b1;
    sb.push_back(e);
    for (int k = 0; k < 200 && !accepted; k++) begin
      @(negedge clk);
      accepted = inReady;
      @(posedge clk);
      #1;
    end
    check("accept_timeout", WIDTH'(accepted), WIDTH'(1));
    inValid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && sb.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_empty", WIDTH'(sb.size()), WIDTH'(0));
  endtask

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       outReady = 1'b1;
      1:       outReady = ~outReady;
      default: outReady = 1'b0;
    endcase
  end

  // Monitor: pops on every consumed beat, checks stall stability and inReady.
  initial begin
    exp_t             e;
    bit               stall_prev = 0;
    logic [WIDTH-1:0] held = '0;
    logic [3:0]       held_f = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 0;
        continue;
      end
      if (stall_prev) begin
        n_stalls++;
        check("stall_valid", WIDTH'(outValid), WIDTH'(1));
        check("stall_result", result, held);
        check("stall_flags", WIDTH'({carryFlag, zeroFlag, overFlowFlag, illegalOp}),
              WIDTH'(held_f));
      end
      if (!outValid || outReady)
        check("inready_free", WIDTH'(inReady), WIDTH'(1));
      if (outValid && outReady) begin
        check("out_expected", WIDTH'(sb.size() != 0), WIDTH'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("carry", WIDTH'(carryFlag), WIDTH'(e.c));
          check("zero", WIDTH'(zeroFlag), WIDTH'(e.z));
          check("ovf", WIDTH'(overFlowFlag), WIDTH'(e.v));
          check("illegal", WIDTH'(illegalOp), WIDTH'(e.ill));
        end
      end
      stall_prev = outValid && !outReady;
      held       = result;
      held_f     = {carryFlag, zeroFlag, overFlowFlag, illegalOp};
    end
  end

  initial begin
    logic exp_sticky;
    rst_n = 1'b0; inValid = 1'b0; opcode = '0; input1 = '0; input2 = '0;
    shiftValue = '0; outReady = 1'b1;
    #12;
    check("rst_outvalid", WIDTH'(outValid), WIDTH'(0));
    check("rst_result", result, '0);
    check("rst_flags", WIDTH'({carryFlag, zeroFlag, overFlowFlag, illegalOp, stickyOverflow}),
          WIDTH'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_inready", WIDTH'(inReady), WIDTH'(1));

    // Directed vectors: op, a, b, shift, {result, carry, zero, ovf, illegal}
    send(4'd7, MAXPOS, 128'd1, '0, mk(MINNEG, 0, 0, 1, 0));          // ADD overflow
    send(4'd8, 128'd5, 128'd5, '0, mk('0, 1, 1, 0, 0));              // SUB equal
    send(4'd0, ENDS, '0, 7'd1, mk(128'd3, 1, 0, 0, 0));              // ROL 1
    send(4'd0, ENDS, '0, 7'd0, mk(ENDS, 0, 0, 0, 0));                // ROL 0
    send(4'd1, ENDS, '0, 7'd1, mk(128'hc000_0000_0000_0000_0000_0000_0000_0000, 1, 0, 0, 0));
    send(4'd12, 128'd9, 128'd3, '0, mk('0, 0, 1, 0, 1));             // illegal
    send(4'd9, ONES, '0, '0, mk(128'd1, 0, 0, 0, 0));                // SLT -1 < 0
    send(4'd5, ONES, '0, '0, mk('0, 0, 1, 0, 0));                    // SLTU
    send(4'd2, 128'd3, 128'd7, '0, mk(128'd7, 0, 0, 0, 0));          // MAX
    send(4'd3, 128'd3, 128'd7, '0, mk(128'd3, 0, 0, 0, 0));          // MIN
    send(4'd4, '0, 128'h1234, '0, mk(ONES, 0, 0, 0, 0));             // NAND
    send(4'd4, ONES, ONES, '0, mk('0, 0, 1, 0, 0));                  // NAND to zero
    send(4'd7, ONES, 128'd1, '0, mk('0, 1, 1, 0, 0));                // ADD carry out
    send(4'd8, '0, 128'd1, '0, mk(ONES, 0, 0, 0, 0));                // SUB borrow
    send(4'd8, MINNEG, 128'd1, '0, mk(MAXPOS, 1, 0, 1, 0));          // SUB overflow
    send(4'd6, 128'hf0f0, 128'h0ff0, '0, mk(128'hff00, 0, 0, 0, 0)); // XOR
    drain();

`ifdef ALU_STICKY_OVERFLOW_EN
    exp_sticky = 1'b1;
`else
    exp_sticky = 1'b0;
`endif
    check("sticky_after_ovf", WIDTH'(stickyOverflow), WIDTH'(exp_sticky));

    // Streaming with toggling backpressure
    rdy_mode = 1;
    for (int i = 0; i < 10; i++)
      send(4'd6, WIDTH'(i), 128'hff, '0, mk(WIDTH'(i) ^ 128'hff, 0, 0, 0, 0));
    drain();
    check("stalls_seen", WIDTH'(n_stalls > 0), WIDTH'(1));
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Reset with two beats in flight
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send(4'd7, MAXPOS, 128'd1, '0, mk(MINNEG, 0, 0, 1, 0));
    send(4'd7, MAXPOS, 128'd1, '0, mk(MINNEG, 0, 0, 1, 0));
    @(posedge clk);
    #3;
    check("inflight_valid", WIDTH'(outValid), WIDTH'(1));
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("async_rst_outvalid", WIDTH'(outValid), WIDTH'(0));
    check("async_rst_result", result, '0);
    check("async_rst_flags", WIDTH'({carryFlag, zeroFlag, overFlowFlag, illegalOp, stickyOverflow}),
          WIDTH'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("post_rst_no_output", WIDTH'(outValid), WIDTH'(0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe_param.md
Name: alu_pipe_param

Overview:
- Parametrised, pipelined successor of the generated combinational ALUs.
- Data width is generic; operation set gains ADD/SUB/SLT with true carry and overflow flags.
- Two register stages with valid/ready handshaking on both sides, so the block can sit directly in a streaming datapath between producer and consumer stages.
- Sustains one operation per cycle with full backpressure support.

Parameters:
- WIDTH, 128, operand/result width in bits; any value ≥ 8.
- SHW, $clog2(WIDTH), width of shiftValue; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- inValid  input  1  operand beat valid
- inReady  output  1  block accepts beat this cycle
- opcode  input  4  operation select
- input1  input  WIDTH  operand A
- input2  input  WIDTH  operand B
- shiftValue  input  SHW  rotate amount
- outValid  output  1  result beat valid
- outReady  input  1  consumer accepts result
- result  output  WIDTH  operation result
- carryFlag  output  1  carry / no-borrow / last rotated-out bit
- zeroFlag  output  1  result == 0
- overFlowFlag  output  1  signed overflow
- illegalOp  output  1  opcode not in the operation table
- stickyOverflow  output  1  see Optional Feature

Behaviour:
- Reset is asynchronous and active-low (rst_n). All stage valids clear. result = 0, all flags = 0, outValid = 0. inReady = 1 from the first clock after release.
- Opcodes:
  - 0 ROL, 1 ROR, 2 MAX (unsigned), 3 MIN (unsigned), 4 NAND, 5 SLTU, 6 XOR, 7 ADD, 8 SUB, 9 SLT (signed).
  - 10–15 are illegal: result = 0, zeroFlag = 1, carry/overflow = 0, illegalOp = 1.
- Stage 1 registers opcode/operands/shiftValue on accept (inValid && inReady).
- Stage 2 computes and registers result and flags. Latency is exactly 2 cycles from accept to outValid when unstalled.
- Stage enables:
  - s2_en = !s2_valid || outReady
  - s1_en = !s1_valid || s2_en
  - inReady = s1_en
  - The combinational outReady→inReady path is permitted.
- Stalled beats hold result and all flags stable while outValid = 1 and outReady = 0. No beat is dropped or duplicated.
- Simultaneous accept and output consume in the same cycle: the pipeline advances by one. Throughput is 1/cycle.
- Rotates:
  - The amount is taken modulo WIDTH; shiftValue = 0 returns input1 unchanged. No shift by WIDTH is allowed.
  - carryFlag = last bit rotated out: ROL gives result[0], ROR gives result[WIDTH-1]. carryFlag = 0 when the amount is 0.
- ADD: WIDTH+1-bit sum. carryFlag = bit WIDTH. overFlowFlag = signs of operands equal and sign of result different.
- SUB: input1 − input2. carryFlag = 1 when there is no borrow (input1 ≥ input2 unsigned). overFlowFlag = operand signs differ and result sign differs from input1.
- SLTU/SLT: result = {WIDTH-1 zeros, lt}.
- MAX/MIN: on tie, return input2 for MAX and input1 for MIN.
- All ops except ADD/SUB/ROL/ROR: carryFlag = 0. All ops except ADD/SUB: overFlowFlag = 0.
- zeroFlag is computed from the final registered result for every opcode.
- Reset mid-operation: in-flight beats are discarded with no output.

Optional Feature:
- Macro: ALU_STICKY_OVERFLOW_EN.
- Defined: stickyOverflow is a register set when a beat with overFlowFlag = 1 is consumed (outValid && outReady). It is cleared only by rst_n.
- Undefined: stickyOverflow is tied to 0 and no register is inferred.

Test Plan:
- ADD, WIDTH=128, input1 = 2^127−1, input2 = 1, outReady = 1 → after 2 cycles: result = 2^127, overFlowFlag = 1, carryFlag = 0, zeroFlag = 0.
- SUB, input1 = 5, input2 = 5 → result = 0, zeroFlag = 1, carryFlag = 1, overFlowFlag = 0.
- ROL, input1 = 128'h8000…0001, shiftValue = 1 → result = 128'h…0003, carryFlag = 1. Repeat with shiftValue = 0 → result = input1, carryFlag = 0.
- Stream 10 XOR beats with inValid held high, toggling outReady 1-0-1-0 → 10 results in order, none lost or duplicated; result stable during stalls; inReady falls only when both stages are full.
- opcode = 12 → illegalOp = 1, result = 0, zeroFlag = 1. SLT with input1 = −1, input2 = 0 → result = 1. SLTU with the same operands → result = 0.
- Assert rst_n = 0 with 2 beats in flight → outValid = 0 and flags = 0 immediately (asynchronous); no output after release. With ALU_STICKY_OVERFLOW_EN defined, stickyOverflow stays 1 after the overflow beat until reset.
